// File: rtl/event_rr_encoder.sv
// event_rr_encoder: rising-edge event capture with pending vector and round-robin/fixed index encoder
module event_rr_encoder #(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] D,
    input  logic       ready,
    output logic [2:0] Y,
    output logic       valid,
    output logic [7:0] pend,
    output logic       ovf
);
    logic [7:0] d_q, d_d, pend_q, pend_d, rise, rot, clr;
    logic [2:0] y_q, y_d, ptr_q, ptr_d, off, sel;
    logic [3:0] base;
    logic       valid_q, valid_d, ovf_q, ovf_d, free, load;
    always_comb begin
        rise    = D & ~d_q;
        free    = !valid_q || ready;
        base    = RR_EN != 0 ? {1'b0, ptr_q} + 4'd1 : 4'd0;
        rot     = 8'({pend_q, pend_q} >> base);
        off     = 3'd0;
        for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
        sel     = base[2:0] + off;
        load    = free && (pend_q != 8'h00);
        clr     = load ? 8'd1 << sel : 8'h00;
        pend_d  = (pend_q & ~clr) | rise;
        ovf_d   = |(rise & pend_q & ~clr);
        valid_d = free ? load : valid_q;
        y_d     = load ? sel : y_q;
        ptr_d   = load ? sel : ptr_q;
        d_d     = D;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= 3'd0;
            valid_q <= 1'b0;
            pend_q  <= 8'h00;
            ovf_q   <= 1'b0;
            ptr_q   <= 3'd7;
            d_q     <= 8'hFF;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            d_q     <= d_d;
        end
    end
    assign Y     = y_q;
    assign valid = valid_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_event_rr_encoder.sv
// tb_event_rr_encoder: random and directed checks of both selection modes against a behavioural model
module tb_event_rr_encoder;
    logic       clk, rst_n, ready, chk_en;
    logic [7:0] D;
    logic [2:0] y0, y1;
    logic       v0, v1, o0, o1;
    logic [7:0] p0, p1;
    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0] pend, dq;
        logic [2:0] y, ptr;
        logic       valid, ovf;
    } mstate_t;

    mstate_t ms0, ms1;

    event_rr_encoder #(.RR_EN(0)) u0 (.clk(clk), .rst_n(rst_n), .D(D), .ready(ready),
                                      .Y(y0), .valid(v0), .pend(p0), .ovf(o0));
    event_rr_encoder #(.RR_EN(1)) u1 (.clk(clk), .rst_n(rst_n), .D(D), .ready(ready),
                                      .Y(y1), .valid(v1), .pend(p1), .ovf(o1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mstate_t step(mstate_t s, bit rr, logic [7:0] d, logic rdy, logic rn);
        mstate_t n;
        int sel;
        logic [7:0] rise;
        if (!rn) begin
            n.pend = 8'h00; n.dq = 8'hFF; n.y = 3'd0; n.ptr = 3'd7; n.valid = 1'b0; n.ovf = 1'b0;
            return n;
        end
        n = s;
        n.dq = d;
        n.ovf = 1'b0;
        rise = d & ~s.dq;
        sel = -1;
        if (!s.valid || rdy) begin
            if (rr) begin
                for (int k = 1; k <= 8; k++)
                    if (sel < 0 && s.pend[(int'(s.ptr) + k) % 8]) sel = (int'(s.ptr) + k) % 8;
            end else begin
                for (int i = 0; i < 8; i++)
                    if (sel < 0 && s.pend[i]) sel = i;
            end
            n.valid = (sel >= 0);
        end
        if (sel >= 0) begin
            n.pend[sel] = 1'b0;
            n.y = 3'(sel);
            n.ptr = 3'(sel);
        end
        for (int i = 0; i < 8; i++)
            if (rise[i]) begin
                if (s.pend[i] && i != sel) n.ovf = 1'b1;
                n.pend[i] = 1'b1;
            end
        return n;
    endfunction

    always @(posedge clk) begin
        ms0 <= step(ms0, 1'b0, D, ready, rst_n);
        ms1 <= step(ms1, 1'b1, D, ready, rst_n);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("m0_y", 32'(y0), 32'(ms0.y));
        chk("m0_valid", 32'(v0), 32'(ms0.valid));
        chk("m0_pend", 32'(p0), 32'(ms0.pend));
        chk("m0_ovf", 32'(o0), 32'(ms0.ovf));
        chk("m1_y", 32'(y1), 32'(ms1.y));
        chk("m1_valid", 32'(v1), 32'(ms1.valid));
        chk("m1_pend", 32'(p1), 32'(ms1.pend));
        chk("m1_ovf", 32'(o1), 32'(ms1.ovf));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int thr;
        chk_en = 1'b0; D = 8'hFF; ready = 1'b1; rst_n = 1'b0;
        tick(); chk_en = 1'b1;
        tick(); rst_n = 1'b1;
        repeat (10) begin
            tick();
            chk("hi_thru_reset_valid", 32'(v1), 0);
            chk("hi_thru_reset_pend", 32'(p1), 0);
            chk("hi_thru_reset_ovf", 32'(o1), 0);
        end
        D = 8'h00; tick();
        D = 8'h04; tick(); chk("lat_pend", 32'(p1), 32'h04); chk("lat_valid0", 32'(v1), 0);
        tick(); chk("lat_valid1", 32'(v1), 1); chk("lat_y", 32'(y1), 2);
        tick(); chk("lat_drain", 32'(v1), 0);
        rst_n = 1'b0; D = 8'h00; tick(); rst_n = 1'b1; tick();
        D = 8'h81; tick(); chk("rr81_pend", 32'(p1), 32'h81);
        tick(); chk("rr81_first", 32'(y1), 0); chk("rr81_v", 32'(v1), 1);
        tick(); chk("rr81_second", 32'(y1), 7);
        tick(); chk("rr81_drain", 32'(v1), 0);
        D = 8'h00; ready = 1'b0; tick();
        D = 8'h08; tick(); chk("t3_pend", 32'(p1), 32'h08);
        D = 8'h00; tick(); chk("t3_load_y", 32'(y1), 3); chk("t3_load_pend", 32'(p1), 0);
        D = 8'h08; tick(); chk("t3_repend", 32'(p1), 32'h08); chk("t3_no_ovf", 32'(o1), 0);
        D = 8'h00; tick();
        D = 8'h08; tick(); chk("t3_ovf", 32'(o1), 1); chk("t3_hold_y", 32'(y1), 3); chk("t3_hold_v", 32'(v1), 1);
        D = 8'h00; tick(); chk("t3_ovf_pulse", 32'(o1), 0);
        ready = 1'b1; tick(); chk("t3_again_y", 32'(y1), 3); chk("t3_again_pend", 32'(p1), 0);
        tick(); chk("t3_drain", 32'(v1), 0);
        rst_n = 1'b0; ready = 1'b0; D = 8'h00; tick(); rst_n = 1'b1; tick();
        D = 8'h01; tick(); tick(); chk("p81_y_m0", 32'(y0), 0); chk("p81_y_m1", 32'(y1), 0);
        D = 8'h00; tick();
        D = 8'h81; tick(); chk("p81_pend", 32'(p1), 32'h81);
        ready = 1'b1; tick(); chk("p81_rr_first", 32'(y1), 7); chk("p81_fix_first", 32'(y0), 0);
        tick(); chk("p81_rr_second", 32'(y1), 0); chk("p81_fix_second", 32'(y0), 7);
        tick(); chk("p81_drain", 32'(v1), 0);
        ready = 1'b0; D = 8'h00; tick();
        D = 8'h01; tick(); tick();
        D = 8'h31; tick(); chk("mid_pend", 32'(p1), 32'h30); chk("mid_valid", 32'(v1), 1);
        rst_n = 1'b0; tick();
        chk("mid_rst_v", 32'(v1), 0); chk("mid_rst_pend", 32'(p1), 0);
        chk("mid_rst_ovf", 32'(o1), 0); chk("mid_rst_y", 32'(y1), 0);
        rst_n = 1'b1; ready = 1'b1;
        repeat (5) begin tick(); chk("mid_no_stale", 32'(v1), 0); end
        thr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) thr = int'($urandom_range(0, 2)) * 40 + 10;
            D = D ^ (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd1 << $urandom_range(0, 7));
            ready = ($urandom_range(0, 99) < thr);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
